// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with a held-instruction register, next-PC logic and a sticky imem timeout fault.
//   Ports: clk, reset (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//   instr/op/funct/instr_valid/pc to decode; retire/pcsrc/jump from the controller; fetch_err sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pc,
  output logic        fetch_err
);
  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
  localparam logic [9:0] LAST = 10'(TIMEOUT - 1);
  state_t state, state_n;
  logic [9:0] cnt;
  logic [31:0] pcplus4, br_target, j_target, next_pc;
  assign pcplus4   = pc + 32'd4;
  assign br_target = pcplus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign j_target  = {pcplus4[31:28], instr[25:0], 2'b00};
  assign next_pc   = jump ? j_target : pcsrc ? br_target : pcplus4;
  always_ff @(posedge clk)
    state <= reset ? FETCH : state_n;
  always_comb begin
    state_n = state;
    state_n = (state == FETCH) ? (imem_ack ? HOLD : (cnt == LAST) ? HALT : FETCH)
            : (state == HOLD && retire) ? FETCH : state;
  end
  // cnt is cleared on every ack, so it is already 0 whenever FETCH is re-entered from HOLD.
  always_ff @(posedge clk)
    if (reset) begin
      pc    <= RESET_PC;
      instr <= '0;
      cnt   <= '0;
    end else begin
      if (state == FETCH) cnt <= imem_ack ? '0 : cnt + 10'd1;
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (state == HOLD && retire) pc <= next_pc;
    end
  assign imem_req    = state == FETCH;
  assign instr_valid = state == HOLD;
  assign fetch_err   = state == HALT;
  assign imem_addr   = pc;
  assign op          = instr[31:26];
  assign funct       = instr[5:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit (wrap-around/timeout instance and a jump-priority instance).
module tb_fetch_unit;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic clk = 0, reset = 1;
  logic ack = 0, retire = 0, pcsrc = 0, jump = 0;
  logic [31:0] rdata = 0;
  logic req, valid, err;
  logic [31:0] addr, instr, pc;
  logic [5:0] op, funct;
  logic ack1 = 0, retire1 = 0, pcsrc1 = 0, jump1 = 0;
  logic [31:0] rdata1 = 0;
  logic req1, valid1, err1;
  logic [31:0] addr1, instr1, pc1;
  logic [5:0] op1, funct1;
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(8)) u0 (
    .clk(clk), .reset(reset), .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .instr(instr), .op(op), .funct(funct), .instr_valid(valid), .retire(retire), .pcsrc(pcsrc),
    .jump(jump), .pc(pc), .fetch_err(err));
  fetch_unit #(.RESET_PC(32'h3FFF_FFFC)) u1 (
    .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
    .instr(instr1), .op(op1), .funct(funct1), .instr_valid(valid1), .retire(retire1), .pcsrc(pcsrc1),
    .jump(jump1), .pc(pc1), .fetch_err(err1));
  task automatic step;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed %h expected queued entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask
  initial begin
    ack = 1; retire = 1; rdata = 32'hDEAD_BEEF;
    step; step; step;
    chk("rst_req", 32'(req), 1);
    chk("rst_addr", addr, 32'hFFFF_FFFC);
    chk("rst_instr", instr, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_err", 32'(err), 0);
    reset = 0; ack = 0; retire = 0;
    step;
    chk("first_req", 32'(req), 1);
    chk("first_addr", addr, 32'hFFFF_FFFC);
    ack = 1; rdata = 32'h2008_0005; push("instr_load", 32'h2008_0005);
    step;
    ack = 0;
    pop_chk(instr);
    chk("valid", 32'(valid), 1);
    chk("op", 32'(op), 32'h08);
    chk("funct", 32'(funct), 32'h05);
    chk("hold_pc", pc, 32'hFFFF_FFFC);
    chk("hold_req", 32'(req), 0);
    retire = 1; push("wrap_addr", 32'h0);
    step;
    retire = 0;
    chk("refetch_req", 32'(req), 1);
    pop_chk(addr);
    retire = 1; jump = 1;
    repeat (7) begin
      step;
      chk("wait_req", 32'(req), 1);
      chk("wait_pc", pc, 0);
    end
    retire = 0; jump = 0; ack = 1; rdata = 32'h0800_0004; push("last_ack_instr", 32'h0800_0004);
    step;
    pop_chk(instr);
    chk("last_ack_valid", 32'(valid), 1);
    rdata = 32'hFFFF_FFFF;
    step;
    ack = 0;
    chk("hold_instr", instr, 32'h0800_0004);
    chk("hold_pc0", pc, 0);
    chk("hold_valid", 32'(valid), 1);
    retire = 1; jump = 1; push("jump_pc", 32'h10);
    step;
    retire = 0; jump = 0;
    pop_chk(pc);
    chk("jump_addr", addr, 32'h10);
    ack = 1; rdata = 32'h1000_FFFF;
    step;
    ack = 0;
    chk("br_valid", 32'(valid), 1);
    retire = 1; pcsrc = 1; push("branch_pc", 32'h10);
    step;
    retire = 0; pcsrc = 0;
    pop_chk(pc);
    chk("branch_req", 32'(req), 1);
    repeat (7) begin
      step;
      chk("to_req", 32'(req), 1);
    end
    step;
    chk("halt_err", 32'(err), 1);
    chk("halt_req", 32'(req), 0);
    chk("halt_valid", 32'(valid), 0);
    ack = 1; retire = 1; rdata = 32'h1234_5678;
    repeat (3) step;
    ack = 0; retire = 0;
    chk("halt_stay", 32'(err), 1);
    chk("halt_pc", pc, 32'h10);
    chk("halt_instr", instr, 32'h1000_FFFF);
    reset = 1;
    step;
    chk("rst2_err", 32'(err), 0);
    chk("rst2_pc", pc, 32'hFFFF_FFFC);
    chk("rst2_instr", instr, 0);
    chk("rst2_req", 32'(req), 1);
    reset = 0;
    step;
    chk("u1_pc", pc1, 32'h3FFF_FFFC);
    chk("u1_req", 32'(req1), 1);
    ack1 = 1; rdata1 = 0;
    step;
    ack1 = 0; retire1 = 1; push("u1_seq_pc", 32'h4000_0000);
    step;
    retire1 = 0;
    pop_chk(pc1);
    ack1 = 1; rdata1 = 32'h0800_0010;
    step;
    ack1 = 0; retire1 = 1; jump1 = 1; pcsrc1 = 1; push("jump_prio_pc", 32'h4000_0040);
    step;
    retire1 = 0; jump1 = 0; pcsrc1 = 0;
    pop_chk(pc1);
    chk("jump_prio_addr", addr1, 32'h4000_0040);
    ack1 = 1; rdata1 = 32'h1234_5678;
    step;
    ack1 = 0;
    chk("u1_hold", 32'(valid1), 1);
    reset = 1; retire1 = 1; jump1 = 1;
    step;
    reset = 0; retire1 = 0; jump1 = 0;
    chk("midhold_pc", pc1, 32'h3FFF_FFFC);
    chk("midhold_instr", instr1, 0);
    chk("midhold_valid", 32'(valid1), 0);
    chk("midhold_req", 32'(req1), 1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter TIMEOUT, default 255, is the maximum number of request cycles without acknowledge before fault; legal range is 1..1023.
REQ-003 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL be asserted while an instruction fetch is outstanding.
REQ-006 imem_addr  output  32  SHALL carry the byte address of the current fetch, equal to pc.
REQ-007 imem_ack  input  1  marks the cycle in which imem_rdata is valid.
REQ-008 imem_rdata  input  32  is the instruction word from instruction memory.
REQ-009 instr  output  32  is the held instruction word.
REQ-010 op  output  6  SHALL equal instr[31:26].
REQ-011 funct  output  6  SHALL equal instr[5:0].
REQ-012 instr_valid  output  1  SHALL be high when instr is held for the decode/execute stage.
REQ-013 retire  input  1  means the consumer has finished the held instruction and pcsrc/jump are valid.
REQ-014 pcsrc  input  1  selects the branch target; it comes from the controller's branch & zero.
REQ-015 jump  input  1  selects the jump target; it comes from the controller.
REQ-016 pc  output  32  is the address of the held or in-flight instruction.
REQ-017 fetch_err  output  1  is a sticky fault flag for an instruction-memory timeout.

Function
REQ-018 The FSM SHALL have three states: FETCH, HOLD and HALT.
REQ-019 imem_req SHALL be 1 only in FETCH, instr_valid SHALL be 1 only in HOLD, and fetch_err SHALL be 1 only in HALT; all are decoded from the state register.
REQ-020 In FETCH with imem_ack=1, instr SHALL be loaded from imem_rdata and the FSM SHALL move to HOLD on the same edge.
REQ-021 The wait counter SHALL be 0 on entry to FETCH and SHALL increment on each FETCH cycle with imem_ack=0.
REQ-022 When the wait counter equals TIMEOUT-1 and imem_ack=0, the FSM SHALL move to HALT.
REQ-023 An imem_ack in the final allowed cycle SHALL count as success.
REQ-024 In HOLD, instr and pc SHALL remain stable until retire=1.
REQ-025 In HOLD with retire=1, pc SHALL load next_pc and the FSM SHALL move to FETCH on the same edge.
REQ-026 pcplus4 SHALL be computed as pc + 4, modulo 2^32.
REQ-027 The branch target SHALL be pcplus4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
REQ-028 The jump target SHALL be {pcplus4[31:28], instr[25:0], 2'b00}.
REQ-029 next_pc selection priority SHALL be: jump first, then pcsrc (branch target), else pcplus4.
REQ-030 imem_ack outside FETCH SHALL be ignored, and retire outside HOLD SHALL be ignored.
REQ-031 HALT SHALL be exited only by reset; in HALT, pc and instr SHALL hold their values.
REQ-032 Minimum throughput SHALL be 2 cycles per instruction: imem_ack in the first FETCH cycle, then retire in the first HOLD cycle.
REQ-033 imem_req SHALL reassert in the cycle after a retire, with imem_addr equal to the new pc.

Reset
REQ-034 When reset=1 at an edge, the block SHALL set pc=RESET_PC, state=FETCH, instr=0, wait counter=0, and fetch_err=0.
REQ-035 While reset=1, imem_ack and retire SHALL have no effect, including when reset is asserted mid-fetch or mid-hold.
REQ-036 In the first cycle after reset deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC.

Verification
REQ-037 Reset release, then imem_ack in the first cycle with imem_rdata=32'h2008_0005 -> next cycle instr_valid=1, op=6'h08, pc=0.
REQ-038 Held instruction, retire=1 with pcsrc=0 and jump=0 -> next cycle imem_req=1 and imem_addr=32'h0000_0004.
REQ-039 pc=32'h10, instr=32'h1000_FFFF, retire with pcsrc=1 -> pc=32'h10.
REQ-040 pc=32'h4000_0000, instr=32'h0800_0010, retire with jump=1 and pcsrc=1 -> pc=32'h4000_0040 (jump has priority).
REQ-041 TIMEOUT=8 with no imem_ack for 8 request cycles -> fetch_err=1 and imem_req=0; the block stays there until reset; an ack on the 8th cycle instead -> HOLD.
REQ-042 RESET_PC=32'hFFFF_FFFC, fetch and retire sequentially -> the next imem_addr=32'h0000_0000 (wrap-around).
